// File: rtl/bp_weight_scheduler_if.sv
// Bundle of the prediction, training-feedback and SRAM signals of the
// perceptron weight scheduler. The master side is the environment
// (branch controller + SRAM), the slave side is the scheduler itself.
interface bp_weight_scheduler_if #(
  parameter int N          = 7,
  parameter int W_BITS     = 6,
  parameter int P_BITS     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                       i_pred_valid;
  logic [P_BITS-1:0]          i_pred_idx;
  logic                       o_pred_grant;
  logic                       o_pred_rvalid;
  logic [N*W_BITS-1:0]        o_pred_row;
  logic                       i_trn_valid;
  logic                       o_trn_ready;
  logic [P_BITS-1:0]          i_trn_idx;
  logic [N-1:0]               i_trn_hist;
  logic                       i_trn_outcome;
  logic                       i_trn_mispredict;
  logic [W_BITS+N-1:0]        i_trn_yabs;
  logic                       o_mem_en;
  logic                       o_mem_we;
  logic [P_BITS-1:0]          o_mem_addr;
  logic [N*W_BITS-1:0]        o_mem_wdata;
  logic [N*W_BITS-1:0]        i_mem_rdata;
  logic                       o_init_busy;
  logic [$clog2(FIFO_DEPTH):0] o_fifo_count;

  modport master (
    output i_pred_valid, i_pred_idx, i_trn_valid, i_trn_idx, i_trn_hist,
           i_trn_outcome, i_trn_mispredict, i_trn_yabs, i_mem_rdata,
    input  o_pred_grant, o_pred_rvalid, o_pred_row, o_trn_ready, o_mem_en,
           o_mem_we, o_mem_addr, o_mem_wdata, o_init_busy, o_fifo_count
  );

  modport slave (
    input  i_pred_valid, i_pred_idx, i_trn_valid, i_trn_idx, i_trn_hist,
           i_trn_outcome, i_trn_mispredict, i_trn_yabs, i_mem_rdata,
    output o_pred_grant, o_pred_rvalid, o_pred_row, o_trn_ready, o_mem_en,
           o_mem_we, o_mem_addr, o_mem_wdata, o_init_busy, o_fifo_count
  );
endinterface

// File: rtl/bp_weight_scheduler.sv
// Perceptron weight SRAM scheduler: clears the table after reset, then
// shares the single SRAM port between prediction row reads and queued
// training read-modify-writes with saturating weight updates.
module bp_weight_scheduler #(
  parameter int N          = 7,
  parameter int W_BITS     = 6,
  parameter int P_BITS     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int THETA      = 27
) (
  input logic                 clk,
  input logic                 rst_n,
  bp_weight_scheduler_if.slave bus
);
  localparam int ROW_BITS = N * W_BITS;
  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;
  localparam int Y_BITS   = W_BITS + N;
  localparam logic [W_BITS-1:0]   W_MAX    = {1'b0, {(W_BITS-1){1'b1}}};
  localparam logic [W_BITS-1:0]   W_MIN    = {1'b1, {(W_BITS-1){1'b0}}};
  localparam logic [W_BITS-1:0]   W_ONE    = {{(W_BITS-1){1'b0}}, 1'b1};
  localparam logic [Y_BITS-1:0]   THETA_Y  = Y_BITS'(THETA);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_TRN_WB = 2'd2
  } state_t;

  // Saturating perceptron update; bias input x[0] is always 1.
  function automatic logic [ROW_BITS-1:0] train_row(
    input logic [ROW_BITS-1:0] row,
    input logic [N-1:0]        hist,
    input logic                outcome
  );
    logic [ROW_BITS-1:0] res;
    logic [W_BITS-1:0]   w;
    logic                x;
    res = row;
    for (int i = 0; i < N; i++) begin
      w = row[i*W_BITS +: W_BITS];
      x = (i == 0) ? 1'b1 : hist[i];
      if (outcome == x) begin
        if (w != W_MAX) w = w + W_ONE;
        else            w = W_MAX;
      end else begin
        if (w != W_MIN) w = w - W_ONE;
        else            w = W_MIN;
      end
      res[i*W_BITS +: W_BITS] = w;
    end
    return res;
  endfunction

  state_t              state_r;
  logic [P_BITS-1:0]   init_cnt_r;
  logic                run_r;
  logic                init_busy_r;
  logic                rvalid_r;
  logic [PTR_BITS-1:0] rd_ptr_r;
  logic [PTR_BITS-1:0] wr_ptr_r;
  logic [CNT_BITS-1:0] count_r;

  logic [P_BITS-1:0]   q_idx_r     [FIFO_DEPTH];
  logic [N-1:0]        q_hist_r    [FIFO_DEPTH];
  logic                q_outcome_r [FIFO_DEPTH];
  logic                q_misp_r    [FIFO_DEPTH];
  logic [Y_BITS-1:0]   q_yabs_r    [FIFO_DEPTH];

  logic                full_s, empty_s, ready_s, push_s, pop_s;
  logic                head_upd_s, grant_s, start_trn_s;
  logic                mem_en_s, mem_we_s;
  logic [P_BITS-1:0]   mem_addr_s;
  logic [ROW_BITS-1:0] mem_wdata_s;
  logic [P_BITS-1:0]   head_idx_s;
  logic [N-1:0]        head_hist_s;
  logic                head_outcome_s;

  assign full_s         = (count_r == CNT_FULL);
  assign empty_s        = (count_r == {CNT_BITS{1'b0}});
  // run_r keeps the queue closed while reset is held and for the release cycle.
  assign ready_s        = run_r && !full_s;
  assign push_s         = bus.i_trn_valid && ready_s;
  assign head_idx_s     = q_idx_r[rd_ptr_r];
  assign head_hist_s    = q_hist_r[rd_ptr_r];
  assign head_outcome_s = q_outcome_r[rd_ptr_r];
  // Confident correct predictions leave the weights alone.
  assign head_upd_s     = q_misp_r[rd_ptr_r] || (q_yabs_r[rd_ptr_r] <= THETA_Y);

  // Per-cycle SRAM port arbitration between clear, training and prediction.
  always_comb begin
    pop_s       = 1'b0;
    grant_s     = 1'b0;
    start_trn_s = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {P_BITS{1'b0}};
    mem_wdata_s = {ROW_BITS{1'b0}};
    case (state_r)
      ST_INIT: begin
        if (run_r) begin
          mem_en_s   = 1'b1;
          mem_we_s   = 1'b1;
          mem_addr_s = init_cnt_r;
        end else begin
          mem_en_s   = 1'b0;
        end
      end
      ST_IDLE: begin
        if (!empty_s && !head_upd_s) begin
          pop_s = 1'b1;
          if (bus.i_pred_valid) begin
            grant_s    = 1'b1;
            mem_en_s   = 1'b1;
            mem_addr_s = bus.i_pred_idx;
          end else begin
            grant_s    = 1'b0;
          end
        end else if (!empty_s && (full_s || !bus.i_pred_valid)) begin
          start_trn_s = 1'b1;
          mem_en_s    = 1'b1;
          mem_addr_s  = head_idx_s;
        end else if (bus.i_pred_valid) begin
          grant_s    = 1'b1;
          mem_en_s   = 1'b1;
          mem_addr_s = bus.i_pred_idx;
        end else begin
          grant_s    = 1'b0;
        end
      end
      ST_TRN_WB: begin
        pop_s       = 1'b1;
        mem_en_s    = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = head_idx_s;
        mem_wdata_s = train_row(bus.i_mem_rdata, head_hist_s, head_outcome_s);
      end
      default: begin
        mem_en_s = 1'b0;
      end
    endcase
  end

  // Control FSM: table clear, idle arbitration, training write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= {P_BITS{1'b0}};
      run_r       <= 1'b0;
      init_busy_r <= 1'b1;
      rvalid_r    <= 1'b0;
    end else begin
      run_r    <= 1'b1;
      rvalid_r <= grant_s;
      case (state_r)
        ST_INIT: begin
          if (run_r) begin
            init_cnt_r <= init_cnt_r + P_BITS'(1);
            if (&init_cnt_r) begin
              state_r     <= ST_IDLE;
              init_busy_r <= 1'b0;
            end
          end
        end
        ST_IDLE: begin
          if (start_trn_s) state_r <= ST_TRN_WB;
        end
        ST_TRN_WB: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_INIT;
          init_cnt_r  <= {P_BITS{1'b0}};
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Training queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {CNT_BITS{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_BITS'(1);
        2'b01:   count_r <= count_r - CNT_BITS'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Training queue payload storage (data only, qualified by the pointers).
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_idx_r[wr_ptr_r]     <= bus.i_trn_idx;
      q_hist_r[wr_ptr_r]    <= bus.i_trn_hist;
      q_outcome_r[wr_ptr_r] <= bus.i_trn_outcome;
      q_misp_r[wr_ptr_r]    <= bus.i_trn_mispredict;
      q_yabs_r[wr_ptr_r]    <= bus.i_trn_yabs;
    end
  end

  assign bus.o_pred_grant  = grant_s;
  assign bus.o_pred_rvalid = rvalid_r;
  assign bus.o_pred_row    = rvalid_r ? bus.i_mem_rdata : {ROW_BITS{1'b0}};
  assign bus.o_trn_ready   = ready_s;
  assign bus.o_mem_en      = mem_en_s;
  assign bus.o_mem_we      = mem_we_s;
  assign bus.o_mem_addr    = mem_addr_s;
  assign bus.o_mem_wdata   = mem_wdata_s;
  assign bus.o_init_busy   = init_busy_r;
  assign bus.o_fifo_count  = count_r;
endmodule

// File: tb/tb_bp_weight_scheduler.sv
// Self-checking bench for bp_weight_scheduler: directed steps followed by a
// randomized phase, checked against an integer weight-table model.
module tb_bp_weight_scheduler;
  localparam int N = 7, WB = 6, PB = 8, D = 4, THETA = 27;
  localparam int RB = N * WB, YB = WB + N;
  localparam int WMAX = (1 << (WB - 1)) - 1;
  localparam int WMIN = -(1 << (WB - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int wt [256][N];
  logic [RB-1:0] sram [256];

  bp_weight_scheduler_if #(.N(N), .W_BITS(WB), .P_BITS(PB), .FIFO_DEPTH(D)) bus ();
  bp_weight_scheduler #(.N(N), .W_BITS(WB), .P_BITS(PB), .FIFO_DEPTH(D), .THETA(THETA))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // SRAM model, one-cycle read latency
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) sram[bus.o_mem_addr] <= bus.o_mem_wdata;
      else              bus.i_mem_rdata <= sram[bus.o_mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 256; r++)
      for (int i = 0; i < N; i++) wt[r][i] = 0;
  endfunction

  function automatic void model_train(input int idx, input logic [N-1:0] hist,
                                      input logic outc, input logic misp, input int yabs);
    int v;
    logic x;
    if (!misp && yabs > THETA) return;
    for (int i = 0; i < N; i++) begin
      x = (i == 0) ? 1'b1 : hist[i];
      v = wt[idx][i] + ((outc == x) ? 1 : -1);
      if (v > WMAX) v = WMAX;
      if (v < WMIN) v = WMIN;
      wt[idx][i] = v;
    end
  endfunction

  function automatic logic [RB-1:0] model_row(input int idx);
    logic [RB-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*WB +: WB] = WB'(wt[idx][i]);
    return r;
  endfunction

  function automatic void note_push();
    model_train(int'(bus.i_trn_idx), bus.i_trn_hist, bus.i_trn_outcome,
                bus.i_trn_mispredict, int'(bus.i_trn_yabs));
  endfunction

  task automatic drive_edge(); @(posedge clk); #1; endtask
  task automatic settle(); #3; endtask

  task automatic set_trn(input logic v, input int idx, input logic [N-1:0] hist,
                         input logic outc, input logic misp, input int yabs);
    bus.i_trn_valid      = v;
    bus.i_trn_idx        = PB'(idx);
    bus.i_trn_hist       = hist;
    bus.i_trn_outcome    = outc;
    bus.i_trn_mispredict = misp;
    bus.i_trn_yabs       = YB'(yabs);
  endtask

  task automatic check_init(input string tag);
    int nwr, bad;
    nwr = 0;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (!bus.o_init_busy) break;
      if (bus.o_mem_en) begin
        if (!bus.o_mem_we || bus.o_mem_addr != PB'(nwr) || bus.o_mem_wdata != '0) bad++;
        nwr++;
      end
      if (bus.o_pred_grant) bad++;
      @(posedge clk); #4;
    end
    check({tag, "_busy_done"}, bus.o_init_busy, 1'b0);
    check({tag, "_writes"}, nwr, 256);
    check({tag, "_addr_data"}, bad, 0);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200; c++) begin
      drive_edge();
      bus.i_trn_valid  = 1'b0;
      bus.i_pred_valid = 1'b0;
      settle();
      if (bus.o_fifo_count == '0) break;
    end
    check({tag, "_drained"}, bus.o_fifo_count, 0);
  endtask

  task automatic pred_read(input string tag, input int idx);
    drive_edge(); bus.i_pred_valid = 1'b1; bus.i_pred_idx = PB'(idx); settle();
    drive_edge(); bus.i_pred_valid = 1'b0; settle();
    check({tag, "_rvalid"}, bus.o_pred_rvalid, 1'b1);
    check({tag, "_row"}, bus.o_pred_row, model_row(idx));
  endtask

  initial begin
    int pushed, bad;
    logic [RB-1:0] exp_row;

    bus.i_pred_valid = 1'b0;
    bus.i_pred_idx   = '0;
    set_trn(1'b0, 0, '0, 1'b0, 1'b0, 0);
    bus.i_mem_rdata <= '0;
    for (int r = 0; r < 256; r++) sram[r] <= RB'({$urandom, $urandom});
    model_clear();

    // reset state
    repeat (2) @(posedge clk);
    #4;
    check("rst_mem_en", bus.o_mem_en, 1'b0);
    check("rst_grant", bus.o_pred_grant, 1'b0);
    check("rst_rvalid", bus.o_pred_rvalid, 1'b0);
    check("rst_busy", bus.o_init_busy, 1'b1);
    check("rst_ready", bus.o_trn_ready, 1'b0);
    check("rst_count", bus.o_fifo_count, 0);

    // release; a pending prediction must not be granted during the clear
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.i_pred_valid = 1'b1;
    bus.i_pred_idx   = 8'h77;
    #3;
    @(posedge clk); #4;
    check("post_rst_ready", bus.o_trn_ready, 1'b1);
    check_init("init");

    // prediction read issued in the same cycle, data one cycle later
    drive_edge(); bus.i_pred_valid = 1'b1; bus.i_pred_idx = 8'h12; settle();
    check("pred_grant", bus.o_pred_grant, 1'b1);
    check("pred_en", bus.o_mem_en, 1'b1);
    check("pred_we", bus.o_mem_we, 1'b0);
    check("pred_addr", bus.o_mem_addr, 8'h12);
    drive_edge(); bus.i_pred_valid = 1'b0; settle();
    check("pred_rvalid", bus.o_pred_rvalid, 1'b1);
    check("pred_row_zero", bus.o_pred_row, model_row(8'h12));

    // single training on a cleared row
    drive_edge(); set_trn(1'b1, 5, 7'b0000011, 1'b1, 1'b1, 10); settle();
    check("trn_ready", bus.o_trn_ready, 1'b1);
    note_push();
    drive_edge(); bus.i_trn_valid = 1'b0; settle();
    check("trn_rd_en", {bus.o_mem_en, bus.o_mem_we}, 2'b10);
    check("trn_rd_addr", bus.o_mem_addr, 8'd5);
    check("trn_rd_count", bus.o_fifo_count, 1);
    drive_edge(); settle();
    check("trn_wb_en", {bus.o_mem_en, bus.o_mem_we}, 2'b11);
    check("trn_wb_addr", bus.o_mem_addr, 8'd5);
    exp_row = {{5{6'h3f}}, 6'h01, 6'h01};
    check("trn_wb_data", bus.o_mem_wdata, exp_row);
    check("trn_wb_model", bus.o_mem_wdata, model_row(5));
    drive_edge(); settle();
    check("trn_done_count", bus.o_fifo_count, 0);
    check("trn_done_en", bus.o_mem_en, 1'b0);

    // saturation: repeated taken updates with hist=0 on one row
    pushed = 0;
    for (int c = 0; c < 400 && pushed < 40; c++) begin
      drive_edge(); set_trn(1'b1, 9, 7'b0, 1'b1, 1'b1, 0); settle();
      if (bus.o_trn_ready) begin note_push(); pushed++; end
    end
    drain("sat");
    exp_row = {{6{6'h20}}, 6'h1f};
    check("sat_row", sram[9], exp_row);
    check("sat_model", sram[9], model_row(9));
    pred_read("sat_pred", 9);

    // confident correct prediction is dropped without an SRAM access
    drive_edge(); set_trn(1'b1, 20, 7'b1010101, 1'b1, 1'b0, 40); settle();
    note_push();
    drive_edge(); bus.i_trn_valid = 1'b0; settle();
    check("skip_count", bus.o_fifo_count, 1);
    check("skip_no_mem", bus.o_mem_en, 1'b0);
    drive_edge(); settle();
    check("skip_popped", bus.o_fifo_count, 0);
    // |y| exactly at threshold still trains
    drive_edge(); set_trn(1'b1, 21, 7'b0110011, 1'b0, 1'b0, 27); settle();
    note_push();
    drive_edge(); bus.i_trn_valid = 1'b0; settle();
    check("theta_rd", {bus.o_mem_en, bus.o_mem_we}, 2'b10);
    check("theta_addr", bus.o_mem_addr, 8'd21);
    drain("theta");
    check("theta_row", sram[21], model_row(21));
    check("skip_row", sram[20], model_row(20));

    // full queue under continuous prediction traffic: training wins
    bus.i_pred_valid = 1'b1;
    bus.i_pred_idx   = 8'd3;
    pushed = 0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      drive_edge(); set_trn(1'b1, 30 + pushed, 7'(pushed * 37), 1'b0, 1'b1, 5); settle();
      if (!bus.o_trn_ready) break;
      if (!bus.o_pred_grant) bad++;
      note_push();
      pushed++;
    end
    check("full_fill_grants", bad, 0);
    check("full_pushed", pushed, D);
    check("full_ready", bus.o_trn_ready, 1'b0);
    check("full_rd_grant", bus.o_pred_grant, 1'b0);
    check("full_rd_en", {bus.o_mem_en, bus.o_mem_we}, 2'b10);
    check("full_rd_addr", bus.o_mem_addr, 8'd30);
    drive_edge(); settle();
    check("full_wb_grant", bus.o_pred_grant, 1'b0);
    check("full_wb_we", {bus.o_mem_en, bus.o_mem_we}, 2'b11);
    check("full_push_ignored", bus.o_fifo_count, D);
    drive_edge(); bus.i_trn_valid = 1'b0; settle();
    check("full_after_count", bus.o_fifo_count, D - 1);
    check("full_after_grant", bus.o_pred_grant, 1'b1);
    drain("full");
    for (int r = 30; r < 34; r++) check("full_row", sram[r], model_row(r));

    // asynchronous reset during the write-back cycle
    drive_edge(); set_trn(1'b1, 40, 7'b1111111, 1'b1, 1'b1, 0); settle();
    note_push();
    drive_edge(); bus.i_trn_valid = 1'b0; settle();
    check("rwb_rd", {bus.o_mem_en, bus.o_mem_we}, 2'b10);
    drive_edge(); #1;
    check("rwb_wb", {bus.o_mem_en, bus.o_mem_we}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("rwb_no_write", bus.o_mem_en, 1'b0);
    check("rwb_count", bus.o_fifo_count, 0);
    check("rwb_busy", bus.o_init_busy, 1'b1);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    check_init("reinit");

    // randomized traffic on a small set of rows
    bad = 0;
    for (int c = 0; c < 800; c++) begin
      drive_edge();
      bus.i_pred_valid = 1'($urandom_range(0, 1));
      bus.i_pred_idx   = PB'($urandom_range(0, 7));
      set_trn(1'($urandom_range(0, 1)), $urandom_range(0, 7), N'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              $urandom_range(20, 40));
      settle();
      if (bus.i_trn_valid && bus.o_trn_ready) note_push();
      if (bus.o_pred_grant && !(bus.o_mem_en && !bus.o_mem_we && bus.o_mem_addr == bus.i_pred_idx))
        bad++;
    end
    check("rand_grant_ops", bad, 0);
    drain("rand");
    for (int r = 0; r < 256; r++) check("rand_row", sram[r], model_row(r));
    for (int r = 0; r < 8; r++) pred_read("rand_pred", r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
